multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Next-generation MIPS control unit. Replaces the single-cycle main decoder with a Moore-style multicycle state machine.
- Drives the shared-memory multicycle datapath: PC, IR, A/B and ALUOut registers, with a single memory for instructions and data.
- Adds variable-latency memory support (MemReady handshake), optional ADDI and J instructions, and an illegal-opcode flag.
- ALU function decode stays in the existing ALU decoder, fed by ALUOp.

Parameters:
- OPCODE_W, 6, opcode field width.
- EN_ADDI, 1, decode ADDI (001000); when 0, 001000 is illegal.
- EN_JUMP, 1, decode J (000010); when 0, 000010 is illegal.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- Opcode  input  OPCODE_W  Instr[31:26], taken from the IR register.
- MemReady  input  1  memory access completes this cycle; tie to 1 for single-cycle memory.
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  output  1  data memory write enable.
- IRWrite  output  1  IR load enable.
- RegDst  output  1  write register select: 0 = rt, 1 = rd.
- MemtoReg  output  1  register write data: 0 = ALUOut, 1 = Data.
- RegWrite  output  1  register file write enable.
- ALUSrcA  output  1  ALU A: 0 = PC, 1 = A.
- ALUSrcB  output  2  ALU B: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- ALUOp  output  2  00 = add, 01 = sub, 10 = funct.
- PCSrc  output  2  00 = ALUResult, 01 = ALUOut, 10 = jump target.
- PCWrite  output  1  unconditional PC write.
- Branch  output  1  PC write if Zero (datapath ANDs with Zero).
- Illegal  output  1  one-cycle pulse on an unsupported opcode in DECODE.

Behaviour:
- States (4-bit): FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX.
- Reset is asynchronous. While reset_n = 0: state = FETCH; MemWrite, IRWrite, RegWrite, PCWrite, Branch and Illegal are all forced to 0; mux selects take their FETCH values.
- A reset asserted mid-instruction aborts it. No partial write occurs after the reset edge.
- Outputs decode from state only, except the MemReady gating described below. Any output not listed for a state is 0.
- FETCH:
  - Outputs: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite and PCWrite equal MemReady.
  - Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - Next state by opcode: 100011/101011 -> MEMADR; 000000 -> RTYPEEX; 000100 -> BEQEX; 001000 -> ADDIEX (if EN_ADDI); 000010 -> JEX (if EN_JUMP).
  - Any other opcode: Illegal=1 for this cycle, next state FETCH, no state-changing write.
- MEMADR:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Next state: MEMRD for lw, MEMWR for sw.
- MEMRD:
  - Outputs: IorD=1.
  - Holds until MemReady=1, then goes to MEMWB.
- MEMWB:
  - Outputs: RegDst=0, MemtoReg=1, RegWrite=1.
  - Next state: FETCH.
- MEMWR:
  - Outputs: IorD=1; MemWrite=1 every cycle in the state (memory samples on MemReady).
  - Holds until MemReady=1, then goes to FETCH.
- RTYPEEX:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - Next state: RTYPEWB.
- RTYPEWB:
  - Outputs: RegDst=1, MemtoReg=0, RegWrite=1.
  - Next state: FETCH.
- BEQEX:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1.
  - Next state: FETCH.
- ADDIEX:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Next state: ADDIWB.
- ADDIWB:
  - Outputs: RegDst=0, MemtoReg=0, RegWrite=1.
  - Next state: FETCH.
- JEX:
  - Outputs: PCSrc=10, PCWrite=1.
  - Next state: FETCH.
- Latency in cycles with MemReady held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle MemReady is low in FETCH, MEMRD or MEMWR adds one cycle.
- An unreachable state encoding recovers to FETCH on the next edge with all write enables at 0.

Decomposition:
- Package ctrl_pkg holds:
  - state typedef and encodings;
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - ALUOp, ALUSrcB and PCSrc codes.
- No sub-module. One file containing a state register, a next-state block and an output-decode block.
- The ALU decoder remains a separate, existing block and is not instantiated here.

Test Plan:
- Reset: reset_n=0 mid-MEMWR -> asynchronously state=FETCH, MemWrite=0, IRWrite=0, PCWrite=0 before the next edge. After release with MemReady=1 -> IRWrite=1, ALUSrcB=01.
- lw (Opcode=100011), MemReady=1 -> FETCH, DECODE, MEMADR, MEMRD, MEMWB. RegWrite=1 and MemtoReg=1 only in cycle 5, then back to FETCH.
- sw (101011) with MemReady low for 2 cycles in MEMWR -> IorD=1 and MemWrite=1 for 3 cycles, RegWrite never 1, total 6 cycles.
- R-type (000000) and beq (000100) -> RTYPEEX has ALUOp=10, RTYPEWB has RegDst=1 and RegWrite=1 (4 cycles). BEQEX has ALUOp=01, PCSrc=01, Branch=1 (3 cycles).
- EN_ADDI=1, EN_JUMP=1: addi (001000) -> ADDIWB has RegWrite=1, RegDst=0 (4 cycles). j (000010) -> JEX has PCSrc=10, PCWrite=1 (3 cycles).
- Illegal: Opcode=111111, and Opcode=000010 with EN_JUMP=0 -> Illegal=1 for exactly 1 cycle in DECODE, then FETCH; no RegWrite, MemWrite or PCWrite pulse.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
package ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JEX     = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_fsm.sv
// Moore multicycle control FSM for the shared-memory MIPS datapath,
// with MemReady stalls, optional ADDI/J and an illegal-opcode pulse.
module multicycle_control_fsm
   import ctrl_pkg::*;
#(
   parameter int OPCODE_W = 6,
   parameter int EN_ADDI  = 1,
   parameter int EN_JUMP  = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [OPCODE_W-1:0] Opcode,
   input  logic                MemReady,
   output logic                IorD,
   output logic                MemWrite,
   output logic                IRWrite,
   output logic                RegDst,
   output logic                MemtoReg,
   output logic                RegWrite,
   output logic                ALUSrcA,
   output logic [1:0]          ALUSrcB,
   output logic [1:0]          ALUOp,
   output logic [1:0]          PCSrc,
   output logic                PCWrite,
   output logic                Branch,
   output logic                Illegal
);

   state_t     state, next;
   logic [5:0] op;

   assign op = 6'(Opcode);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= FETCH;
      else          state <= next;
   end

   always_comb begin
      next     = FETCH;
      IorD     = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegDst   = 1'b0;
      MemtoReg = 1'b0;
      RegWrite = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = SRCB_B;
      ALUOp    = ALUOP_ADD;
      PCSrc    = PCSRC_ALU;
      PCWrite  = 1'b0;
      Branch   = 1'b0;
      Illegal  = 1'b0;
      unique case (state)
         FETCH: begin
            ALUSrcB = SRCB_FOUR;
            // state is already FETCH in reset; gate the MemReady-driven enables
            IRWrite = MemReady & reset_n;
            PCWrite = MemReady & reset_n;
            next    = MemReady ? DECODE : FETCH;
         end
         DECODE: begin
            ALUSrcB = SRCB_IMMSH;
            if (op == OP_LW || op == OP_SW)       next = MEMADR;
            else if (op == OP_RTYPE)              next = RTYPEEX;
            else if (op == OP_BEQ)                next = BEQEX;
            else if (op == OP_ADDI && EN_ADDI != 0) next = ADDIEX;
            else if (op == OP_J && EN_JUMP != 0)  next = JEX;
            else                                  Illegal = 1'b1;
         end
         MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            next    = (op == OP_LW) ? MEMRD : MEMWR;
         end
         MEMRD: begin
            IorD = 1'b1;
            next = MemReady ? MEMWB : MEMRD;
         end
         MEMWB: begin
            MemtoReg = 1'b1;
            RegWrite = 1'b1;
         end
         MEMWR: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
            next     = MemReady ? FETCH : MEMWR;
         end
         RTYPEEX: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALUOP_FUNCT;
            next    = RTYPEWB;
         end
         RTYPEWB: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
         end
         BEQEX: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALUOP_SUB;
            PCSrc   = PCSRC_ALUOUT;
            Branch  = 1'b1;
         end
         ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            next    = ADDIWB;
         end
         ADDIWB: RegWrite = 1'b1;
         JEX: begin
            PCSrc   = PCSRC_JUMP;
            PCWrite = 1'b1;
         end
         default: next = FETCH;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized check of two control FSM builds (all options on / ADDI+J off)
// against a per-instruction phase-list model of the instruction timing.
module tb_multicycle_control_fsm;

   typedef struct {
      logic [15:0] outs;
      bit          waits;
      bit          fetch;
   } phase_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [5:0] op [2];
   logic       mr [2];
   logic [15:0] obs [2];

   phase_t q [2][$];
   logic [5:0] plan_op [2][$];
   bit         plan_mr [2][$];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic iord, mw, irw, rd, m2r, rw, sa, pcw, br, ill;
      logic [1:0] sb, aop, pcs;
      multicycle_control_fsm #(
         .OPCODE_W(6),
         .EN_ADDI(g == 0 ? 1 : 0),
         .EN_JUMP(g == 0 ? 1 : 0)
      ) dut (
         .clk(clk), .reset_n(reset_n), .Opcode(op[g]), .MemReady(mr[g]),
         .IorD(iord), .MemWrite(mw), .IRWrite(irw), .RegDst(rd),
         .MemtoReg(m2r), .RegWrite(rw), .ALUSrcA(sa), .ALUSrcB(sb),
         .ALUOp(aop), .PCSrc(pcs), .PCWrite(pcw), .Branch(br),
         .Illegal(ill)
      );
      assign obs[g] = {iord, mw, irw, rd, m2r, rw, sa, sb, aop, pcs,
                       pcw, br, ill};
   end

   function automatic logic [15:0] mk(
      bit iord, bit mw, bit irw, bit rd, bit m2r, bit rw, bit sa,
      logic [1:0] sb, logic [1:0] aop, logic [1:0] pcs,
      bit pcw, bit br, bit ill);
      return {iord, mw, irw, rd, m2r, rw, sa, sb, aop, pcs, pcw, br, ill};
   endfunction

   function automatic phase_t ph(logic [15:0] o, bit w, bit f);
      phase_t p;
      p.outs = o; p.waits = w; p.fetch = f;
      return p;
   endfunction

   // Build the cycle-by-cycle plan of one instruction from the ISA rules.
   task automatic build(int d, logic [5:0] o);
      bit legal_addi, legal_j, ill;
      legal_addi = (d == 0);
      legal_j    = (d == 0);
      ill = !(o == 6'b100011 || o == 6'b101011 || o == 6'b000000 ||
              o == 6'b000100 || (o == 6'b001000 && legal_addi) ||
              (o == 6'b000010 && legal_j));
      q[d].push_back(ph(mk(0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0,0), 1, 1));
      q[d].push_back(ph(mk(0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0,ill), 0, 0));
      if (ill) return;
      case (o)
         6'b100011: begin
            q[d].push_back(ph(mk(0,0,0,0,0,0,1,2'b10,0,0,0,0,0), 0, 0));
            q[d].push_back(ph(mk(1,0,0,0,0,0,0,0,0,0,0,0,0), 1, 0));
            q[d].push_back(ph(mk(0,0,0,0,1,1,0,0,0,0,0,0,0), 0, 0));
         end
         6'b101011: begin
            q[d].push_back(ph(mk(0,0,0,0,0,0,1,2'b10,0,0,0,0,0), 0, 0));
            q[d].push_back(ph(mk(1,1,0,0,0,0,0,0,0,0,0,0,0), 1, 0));
         end
         6'b000000: begin
            q[d].push_back(ph(mk(0,0,0,0,0,0,1,2'b00,2'b10,0,0,0,0), 0, 0));
            q[d].push_back(ph(mk(0,0,0,1,0,1,0,0,0,0,0,0,0), 0, 0));
         end
         6'b000100:
            q[d].push_back(ph(mk(0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0,1,0), 0, 0));
         6'b001000: begin
            q[d].push_back(ph(mk(0,0,0,0,0,0,1,2'b10,0,0,0,0,0), 0, 0));
            q[d].push_back(ph(mk(0,0,0,0,0,1,0,0,0,0,0,0,0), 0, 0));
         end
         default:
            q[d].push_back(ph(mk(0,0,0,0,0,0,0,0,0,2'b10,1,0,0), 0, 0));
      endcase
   endtask

   task automatic chk(string tag, logic [15:0] o, logic [15:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   function automatic logic [5:0] rand_op();
      logic [5:0] tbl [8];
      tbl = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
              6'b001000, 6'b000010, 6'b111111, 6'b000000};
      tbl[7] = 6'($urandom);
      return tbl[$urandom_range(7)];
   endfunction

   // One clock cycle for both DUTs; entered between edges, leaves #1
   // after the next rising edge.
   task automatic step();
      logic [15:0] e;
      for (int d = 0; d < 2; d++) begin
         if (q[d].size() == 0) begin
            op[d] = (plan_op[d].size() != 0) ? plan_op[d].pop_front()
                                             : rand_op();
            build(d, op[d]);
         end
         mr[d] = (plan_mr[d].size() != 0) ? plan_mr[d].pop_front()
                                          : ($urandom_range(3) != 0);
      end
      #1;
      for (int d = 0; d < 2; d++) begin
         e = q[d][0].outs;
         if (q[d][0].fetch && mr[d])
            e = e | mk(0,0,1,0,0,0,0,0,0,0,1,0,0);
         chk($sformatf("dut%0d op=%b mr=%b", d, op[d], mr[d]), obs[d], e);
         if (!q[d][0].waits || mr[d]) void'(q[d].pop_front());
      end
      @(posedge clk);
      #1;
   endtask

   localparam logic [15:0] RST_OUT = 16'h0080;

   initial begin
      op[0] = '0; op[1] = '0; mr[0] = 1'b1; mr[1] = 1'b1;
      #2;
      chk("reset0", obs[0], RST_OUT);
      chk("reset1", obs[1], RST_OUT);
      @(negedge clk);
      reset_n = 1'b1;

      // sw held in MEMWR, then reset mid-write
      plan_op[0].push_back(6'b101011);
      plan_mr[0] = '{1, 1, 1, 0};
      repeat (4) step();
      mr[0] = 1'b0;
      #1;
      chk("memwr_hold", obs[0] & 16'hC000, 16'hC000);
      mr[0] = 1'b1;
      mr[1] = 1'b1;
      reset_n = 1'b0;
      #1;
      chk("async_reset", obs[0], RST_OUT);
      @(negedge clk);
      reset_n = 1'b1;
      q[0].delete();
      q[1].delete();
      #1;
      chk("post_release", obs[0] & 16'h2180, 16'h2080);

      // directed instructions on the full build
      plan_op[0] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                     6'b001000, 6'b000010, 6'b111111};
      plan_mr[0] = '{1,1,1,1,1, 1,1,1,0,0,1, 1,1,1,1, 1,1,1,
                     1,1,1,1, 1,1,1, 1,1};
      // addi and j must flag illegal when disabled
      plan_op[1] = '{6'b000010, 6'b001000, 6'b111111};
      plan_mr[1] = '{1,1, 1,1, 1,1};
      while (plan_mr[0].size() != 0 || q[0].size() != 0) step();

      repeat (400) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
